// File: rtl/axi3_slave_mem.sv
// AXI3 32-bit slave responder backed by an internal word memory.
// Independent write and read FSMs; FIXED/INCR bursts of 1..16 beats, SLVERR/DECERR on bad requests.
module axi3_slave_mem #(
  parameter int          DEPTH     = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] awaddr,
  input  logic [3:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic [5:0]  awid,
  input  logic        wvalid,
  output logic        wready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic [5:0]  wid,
  output logic        bvalid,
  input  logic        bready,
  output logic [1:0]  bresp,
  output logic [5:0]  bid,
  input  logic        arvalid,
  output logic        arready,
  input  logic [31:0] araddr,
  input  logic [3:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  input  logic [5:0]  arid,
  output logic        rvalid,
  input  logic        rready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic [5:0]  rid,
  output logic        rlast,
  output logic [2:0]  dbg_state
);
  // Handshakes: a transfer happens on a rising clock edge where valid and ready are both high;
  // valid never depends combinationally on ready, and ready never depends on valid.
  localparam int IW = $clog2(DEPTH);
  localparam logic [IW-1:0] IDX_ONE = IW'(1);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_DATA} rstate_t;

  logic [31:0] mem [DEPTH];
  logic        live;

  wstate_t     w_state, w_next;
  logic [5:0]  w_id;
  logic [IW-1:0] w_idx;
  logic [3:0]  w_len, w_cnt;
  logic        w_fixed;
  logic [1:0]  w_req_err, w_resp;

  rstate_t     r_state, r_next;
  logic [5:0]  r_id;
  logic [IW-1:0] r_idx, r_idx_next;
  logic [3:0]  r_len, r_cnt;
  logic        r_fixed;
  logic [1:0]  r_err;
  logic [31:0] r_data;

  logic [1:0]  aw_err, ar_err;
  logic        aw_hs, w_hs, ar_hs, r_hs;
  logic        w_cnt_end, w_end, w_beat_bad, w_we, r_last;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^{awaddr[1:0], araddr[1:0]};

  // DECERR outranks SLVERR.
  always_comb begin
    aw_err = 2'b00;
    if (awaddr[31:IW+2] != BASE_ADDR[31:IW+2]) aw_err = 2'b11;
    else if (awsize != 3'b010 || awburst == 2'b10 || awburst == 2'b11) aw_err = 2'b10;
    ar_err = 2'b00;
    if (araddr[31:IW+2] != BASE_ADDR[31:IW+2]) ar_err = 2'b11;
    else if (arsize != 3'b010 || arburst == 2'b10 || arburst == 2'b11) ar_err = 2'b10;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) live <= 1'b0;
    else        live <= 1'b1;
  end

  assign aw_hs      = awvalid && awready;
  assign w_hs       = wvalid && wready;
  assign w_cnt_end  = (w_cnt == w_len);
  assign w_end      = wlast || w_cnt_end;
  assign w_beat_bad = (wid != w_id) || (wlast != w_cnt_end);
  assign w_we       = w_hs && (w_req_err == 2'b00) && (wid == w_id);

  always_comb begin
    w_next  = w_state;
    awready = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b0;
    case (w_state)
      W_IDLE: begin
        awready = live;
        if (awvalid && live) w_next = W_DATA;
      end
      W_DATA: begin
        wready = 1'b1;
        if (wvalid && w_end) w_next = W_RESP;
      end
      W_RESP: begin
        bvalid = 1'b1;
        if (bready) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  assign bresp = bvalid ? w_resp : 2'b00;
  assign bid   = bvalid ? w_id : 6'd0;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      w_state   <= W_IDLE;
      w_id      <= '0;
      w_idx     <= '0;
      w_len     <= '0;
      w_cnt     <= '0;
      w_fixed   <= 1'b0;
      w_req_err <= 2'b00;
      w_resp    <= 2'b00;
    end else begin
      w_state <= w_next;
      if (aw_hs) begin
        w_id      <= awid;
        w_idx     <= awaddr[IW+1:2];
        w_len     <= awlen;
        w_cnt     <= 4'd0;
        w_fixed   <= (awburst == 2'b00);
        w_req_err <= aw_err;
        w_resp    <= aw_err;
      end
      if (w_hs) begin
        w_cnt <= w_cnt + 4'd1;
        if (!w_fixed) w_idx <= w_idx + IDX_ONE;
        // Sticky worst error: never downgrade a latched DECERR.
        if (w_beat_bad && w_resp == 2'b00) w_resp <= 2'b10;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (w_we) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) mem[w_idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign ar_hs      = arvalid && arready;
  assign r_hs       = rvalid && rready;
  assign r_last     = (r_cnt == r_len);
  assign r_idx_next = r_fixed ? r_idx : r_idx + IDX_ONE;

  always_comb begin
    r_next  = r_state;
    arready = 1'b0;
    rvalid  = 1'b0;
    case (r_state)
      R_IDLE: begin
        arready = live;
        if (arvalid && live) r_next = R_DATA;
      end
      R_DATA: begin
        rvalid = 1'b1;
        if (rready && r_last) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  assign rdata = rvalid ? r_data : 32'd0;
  assign rresp = rvalid ? r_err : 2'b00;
  assign rid   = rvalid ? r_id : 6'd0;
  assign rlast = rvalid && r_last;

  // Memory reads here see the pre-write value of a word written in the same cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= R_IDLE;
      r_id    <= '0;
      r_idx   <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_fixed <= 1'b0;
      r_err   <= 2'b00;
      r_data  <= '0;
    end else begin
      r_state <= r_next;
      if (ar_hs) begin
        r_id    <= arid;
        r_idx   <= araddr[IW+1:2];
        r_len   <= arlen;
        r_cnt   <= 4'd0;
        r_fixed <= (arburst == 2'b00);
        r_err   <= ar_err;
        r_data  <= (ar_err != 2'b00) ? 32'd0 : mem[araddr[IW+1:2]];
      end else if (r_hs && !r_last) begin
        r_cnt  <= r_cnt + 4'd1;
        r_idx  <= r_idx_next;
        r_data <= (r_err != 2'b00) ? 32'd0 : mem[r_idx_next];
      end
    end
  end

  assign dbg_state = {r_state, w_state};

endmodule

// File: tb/tb_axi3_slave_mem.sv
// Self-checking bench for axi3_slave_mem: bus driver tasks, a memory model and a read-data scoreboard.
module tb_axi3_slave_mem;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        awvalid = 0, awready;
  logic [31:0] awaddr = 0;
  logic [3:0]  awlen = 0;
  logic [2:0]  awsize = 0;
  logic [1:0]  awburst = 0;
  logic [5:0]  awid = 0;
  logic        wvalid = 0, wready;
  logic [31:0] wdata = 0;
  logic [3:0]  wstrb = 0;
  logic        wlast = 0;
  logic [5:0]  wid = 0;
  logic        bvalid, bready = 0;
  logic [1:0]  bresp;
  logic [5:0]  bid;
  logic        arvalid = 0, arready;
  logic [31:0] araddr = 0;
  logic [3:0]  arlen = 0;
  logic [2:0]  arsize = 0;
  logic [1:0]  arburst = 0;
  logic [5:0]  arid = 0;
  logic        rvalid, rready = 0;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic [5:0]  rid;
  logic        rlast;
  logic [2:0]  dbg_state;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];
  logic [31:0] model [256];
  logic [31:0] wbuf [16];

  axi3_slave_mem #(.DEPTH(256), .BASE_ADDR(32'h0000_0000)) dut (
    .clock(clock), .reset(reset),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen),
    .awsize(awsize), .awburst(awburst), .awid(awid),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wid(wid),
    .bvalid(bvalid), .bready(bready), .bresp(bresp), .bid(bid),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen),
    .arsize(arsize), .arburst(arburst), .arid(arid),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rid(rid), .rlast(rlast),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time exceeded, vectors=%0d required=finish", n_vec);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic aw_send(input logic [31:0] addr, input logic [3:0] len, input logic [2:0] size,
                         input logic [1:0] burst, input logic [5:0] id);
    int n = 0;
    @(negedge clock);
    awvalid = 1; awaddr = addr; awlen = len; awsize = size; awburst = burst; awid = id;
    while (!awready && n < 100) begin @(negedge clock); n++; end
    if (n >= 100) check("aw_timeout", 1, 0);
    @(posedge clock); #1 awvalid = 0;
  endtask

  task automatic w_send(input int nbeats, input int wlast_beat, input int bad_beat,
                        input logic [5:0] id, input logic [3:0] strb);
    for (int i = 0; i < nbeats; i++) begin
      int n = 0;
      @(negedge clock);
      wvalid = 1; wdata = wbuf[i]; wstrb = strb; wlast = (i == wlast_beat);
      wid = (i == bad_beat) ? (id ^ 6'h01) : id;
      while (!wready && n < 100) begin @(negedge clock); n++; end
      if (n >= 100) check("w_timeout", 1, 0);
      @(posedge clock); #1;
    end
    wvalid = 0; wlast = 0;
  endtask

  task automatic b_recv(input logic [1:0] exp_resp, input logic [5:0] exp_id, input int stall);
    int n = 0;
    @(negedge clock);
    while (!bvalid && n < 100) begin @(negedge clock); n++; end
    if (n >= 100) check("b_timeout", 1, 0);
    repeat (stall) begin @(negedge clock); check("b_hold", bvalid, 1); end
    check("bresp", bresp, exp_resp);
    check("bid", bid, exp_id);
    bready = 1;
    @(posedge clock); #1 bready = 0;
    @(negedge clock);
    check("aw_reready", awready, 1);
  endtask

  task automatic ar_send(input logic [31:0] addr, input logic [3:0] len, input logic [2:0] size,
                         input logic [1:0] burst, input logic [5:0] id);
    int n = 0;
    @(negedge clock);
    arvalid = 1; araddr = addr; arlen = len; arsize = size; arburst = burst; arid = id;
    while (!arready && n < 100) begin @(negedge clock); n++; end
    if (n >= 100) check("ar_timeout", 1, 0);
    @(posedge clock); #1 arvalid = 0;
    check("r_latency", rvalid, 1);
  endtask

  task automatic r_recv(input int nb, input logic [5:0] id, input logic [1:0] exp_resp,
                        input bit toggle, input int stall);
    int beat = 0;
    int cyc = 0;
    bit stalled = 0;
    logic [31:0] prev = 0;
    while (beat < nb && cyc < 400) begin
      @(negedge clock);
      rready = toggle ? cyc[0] : (cyc >= stall);
      if (rvalid) begin
        if (stalled) check("r_stable", rdata, prev);
        if (rready) begin
          check("rdata", rdata, exp_q.pop_front());
          check("rlast", rlast, (beat == nb - 1));
          check("rresp", rresp, exp_resp);
          check("rid", rid, id);
          beat++;
          stalled = 0;
        end else begin
          prev = rdata;
          stalled = 1;
        end
      end
      cyc++;
    end
    if (beat < nb) check("r_timeout", beat, nb);
    @(posedge clock); #1 rready = 0;
  endtask

  task automatic write_burst(input logic [31:0] addr, input logic [3:0] len, input logic [2:0] size,
                             input logic [1:0] burst, input logic [5:0] id, input int nbeats,
                             input int wlast_beat, input int bad_beat, input logic [3:0] strb,
                             input bit commit, input logic [1:0] exp_resp, input int bstall);
    aw_send(addr, len, size, burst, id);
    w_send(nbeats, wlast_beat, bad_beat, id, strb);
    b_recv(exp_resp, id, bstall);
    if (commit) begin
      for (int i = 0; i < nbeats; i++) begin
        if (i != bad_beat) begin
          logic [7:0] idx;
          idx = addr[9:2] + ((burst == 2'b01) ? i[7:0] : 8'd0);
          for (int b = 0; b < 4; b++)
            if (strb[b]) model[idx][8*b +: 8] = wbuf[i][8*b +: 8];
        end
      end
    end
  endtask

  task automatic read_burst(input logic [31:0] addr, input logic [3:0] len, input logic [2:0] size,
                            input logic [1:0] burst, input logic [5:0] id, input logic [1:0] exp_resp,
                            input bit zero, input bit toggle, input int stall);
    for (int i = 0; i <= int'(len); i++) begin
      logic [7:0] idx;
      idx = addr[9:2] + ((burst == 2'b01) ? i[7:0] : 8'd0);
      exp_q.push_back(zero ? 32'd0 : model[idx]);
    end
    ar_send(addr, len, size, burst, id);
    r_recv(int'(len) + 1, id, exp_resp, toggle, stall);
  endtask

  initial begin
    repeat (2) @(negedge clock);
    check("rst_awready", awready, 0);
    check("rst_arready", arready, 0);
    check("rst_wready", wready, 0);
    check("rst_bvalid", bvalid, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_state", dbg_state, 0);
    reset = 1;
    #1 check("prelive_awready", awready, 0);
    @(negedge clock);
    check("live_awready", awready, 1);
    check("live_arready", arready, 1);

    // single beat round trip
    wbuf[0] = 32'hDEADBEEF;
    write_burst(32'h10, 0, 3'b010, 2'b01, 6'd5, 1, 0, -1, 4'hF, 1, 2'b00, 0);
    read_burst(32'h10, 0, 3'b010, 2'b01, 6'd5, 2'b00, 0, 0, 0);

    // INCR wrap across the top of memory, read with rready toggling
    for (int i = 0; i < 4; i++) wbuf[i] = i + 1;
    write_burst(32'h3F8, 3, 3'b010, 2'b01, 6'd1, 4, 3, -1, 4'hF, 1, 2'b00, 0);
    read_burst(32'h3F8, 3, 3'b010, 2'b01, 6'd1, 2'b00, 0, 1, 0);

    // byte strobes
    wbuf[0] = 32'h11223344;
    write_burst(32'h20, 0, 3'b010, 2'b01, 6'd2, 1, 0, -1, 4'hF, 1, 2'b00, 0);
    wbuf[0] = 32'hAABBCCDD;
    write_burst(32'h20, 0, 3'b010, 2'b01, 6'd2, 1, 0, -1, 4'b0101, 1, 2'b00, 0);
    check("strb_model", model[8], 32'h11BB33DD);
    read_burst(32'h20, 0, 3'b010, 2'b01, 6'd2, 2'b00, 0, 0, 0);

    // FIXED burst holds the index
    wbuf[0] = 32'h0000_0A0A; wbuf[1] = 32'h0000_0B0B;
    write_burst(32'h40, 1, 3'b010, 2'b00, 6'd4, 2, 1, -1, 4'hF, 1, 2'b00, 0);
    read_burst(32'h40, 1, 3'b010, 2'b00, 6'd4, 2'b00, 0, 0, 0);

    // request errors
    wbuf[0] = 32'h55; wbuf[1] = 32'h66;
    write_burst(32'h400, 1, 3'b010, 2'b01, 6'd3, 2, 1, -1, 4'hF, 0, 2'b11, 0);
    read_burst(32'h0, 0, 3'b010, 2'b01, 6'd3, 2'b00, 0, 0, 0);
    read_burst(32'h10, 0, 3'b001, 2'b01, 6'd4, 2'b10, 1, 0, 0);
    read_burst(32'h800, 1, 3'b010, 2'b01, 6'd4, 2'b11, 1, 0, 0);
    write_burst(32'h10, 0, 3'b010, 2'b11, 6'd6, 1, 0, -1, 4'hF, 0, 2'b10, 0);
    read_burst(32'h10, 0, 3'b010, 2'b01, 6'd6, 2'b00, 0, 0, 0);

    // early wlast, missing wlast, wid mismatch
    wbuf[0] = 32'hC0DE0001; wbuf[1] = 32'hC0DE0002;
    write_burst(32'h80, 3, 3'b010, 2'b01, 6'd6, 2, 1, -1, 4'hF, 1, 2'b10, 0);
    read_burst(32'h80, 1, 3'b010, 2'b01, 6'd6, 2'b00, 0, 0, 0);
    write_burst(32'hA0, 1, 3'b010, 2'b01, 6'd7, 2, -1, -1, 4'hF, 1, 2'b10, 0);
    wbuf[0] = 32'h0101_0101; wbuf[1] = 32'h0202_0202;
    write_burst(32'hC0, 1, 3'b010, 2'b01, 6'd8, 2, 1, -1, 4'hF, 1, 2'b00, 0);
    wbuf[0] = 32'hBAD0_0001; wbuf[1] = 32'h600D_0002;
    write_burst(32'hC0, 1, 3'b010, 2'b01, 6'd8, 2, 1, 0, 4'hF, 1, 2'b10, 0);
    read_burst(32'hC0, 1, 3'b010, 2'b01, 6'd8, 2'b00, 0, 0, 0);

    // concurrent 16-beat write and read with stalled responses
    for (int i = 0; i < 16; i++) wbuf[i] = 32'h1000 + i;
    write_burst(32'h100, 15, 3'b010, 2'b01, 6'd9, 16, 15, -1, 4'hF, 1, 2'b00, 0);
    for (int i = 0; i < 16; i++) wbuf[i] = 32'h2000 + $urandom_range(0, 32'hFFFF);
    fork
      write_burst(32'h200, 15, 3'b010, 2'b01, 6'd9, 16, 15, -1, 4'hF, 1, 2'b00, 5);
      read_burst(32'h100, 15, 3'b010, 2'b01, 6'd10, 2'b00, 0, 0, 5);
    join
    read_burst(32'h200, 15, 3'b010, 2'b01, 6'd11, 2'b00, 0, 0, 0);

    // reset in the middle of a read burst
    ar_send(32'h100, 3, 3'b010, 2'b01, 6'd12);
    repeat (2) @(negedge clock);
    check("pre_rst_rvalid", rvalid, 1);
    #2 reset = 0;
    #1 check("rst_mid_rvalid", rvalid, 0);
    check("rst_mid_arready", arready, 0);
    @(negedge clock);
    reset = 1;
    #1 check("rel_arready", arready, 0);
    @(negedge clock);
    check("rel1_arready", arready, 1);
    check("rel1_awready", awready, 1);
    read_burst(32'h10, 0, 3'b010, 2'b01, 6'd13, 2'b00, 0, 0, 0);
    check("exp_q_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
